mpeg_stream_feeder: RTL and testbench

- Sits between the dual-clock mpeg FIFO read port (32-bit words) and the mpeg2 decoder byte-stream input.
- Pops one word at a time, serialises it into 4 bytes and presents each byte as stream_data/stream_valid, honouring the decoder's mpeg2_busy back-pressure.
- Gates feeding with play/pause, discards buffered data on flush (frame search), and reports byte count, underrun and protocol errors.

---
 rtl/ldp_stream_pkg.sv | 16 +
 rtl/ldp_word_serializer.sv | 56 +++++
 rtl/mpeg_stream_feeder.sv | 178 +++++++++++++++++
 tb/tb_mpeg_stream_feeder.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/ldp_stream_pkg.sv
// Shared types for the MPEG byte-stream feeder: FSM states, byte-lane index
// and word geometry.
package ldp_stream_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_SEND = 2'd2
  } feed_state_e;

  typedef logic [1:0] byte_idx_t;

  localparam int        BYTES_PER_WORD = 4;
  localparam byte_idx_t LAST_IDX       = byte_idx_t'(BYTES_PER_WORD - 1);

endpackage

// File: rtl/ldp_word_serializer.sv
// Holds one 32-bit FIFO word and steps through its four bytes in the
// configured endian order.
module ldp_word_serializer
  import ldp_stream_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1
) (
  input  logic        sys_clk,
  input  logic        rst_n,
  input  logic        clear,
  input  logic        load,
  input  logic [31:0] word,
  input  logic        advance,
  output logic [7:0]  cur_byte,
  output logic        last_byte
);

  logic [31:0] hold_r;
  byte_idx_t   idx_r;

  function automatic logic [7:0] pick_byte(input logic [31:0] w, input byte_idx_t i);
    byte_idx_t lane_s;
    lane_s = BIG_ENDIAN ? (LAST_IDX - i) : i;
    case (lane_s)
      2'd0:    pick_byte = w[7:0];
      2'd1:    pick_byte = w[15:8];
      2'd2:    pick_byte = w[23:16];
      2'd3:    pick_byte = w[31:24];
      default: pick_byte = 8'h00;
    endcase
  endfunction

  assign cur_byte  = pick_byte(hold_r, idx_r);
  assign last_byte = (idx_r == LAST_IDX);

  // Holding register and byte index; clear beats load beats advance.
  always_ff @(posedge sys_clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_r <= 32'h0000_0000;
      idx_r  <= 2'd0;
    end else if (clear) begin
      hold_r <= 32'h0000_0000;
      idx_r  <= 2'd0;
    end else if (load) begin
      hold_r <= word;
      idx_r  <= 2'd0;
    end else if (advance) begin
      hold_r <= hold_r;
      idx_r  <= idx_r + 2'd1;
    end else begin
      hold_r <= hold_r;
      idx_r  <= idx_r;
    end
  end

endmodule

// File: rtl/mpeg_stream_feeder.sv
// Pops 32-bit words from the mpeg FIFO and feeds them byte by byte to the
// mpeg2 decoder, with play/pause gating, flush and status reporting.
module mpeg_stream_feeder
  import ldp_stream_pkg::*;
#(
  parameter bit BIG_ENDIAN = 1'b1,
  parameter int CNT_W      = 32
) (
  input  logic             sys_clk,
  input  logic             RESET_N,
  input  logic             play,
  input  logic             pause,
  input  logic             flush,
  input  logic [31:0]      fifo_dout,
  input  logic             fifo_empty,
  input  logic             fifo_valid,
  output logic             fifo_rd_en,
  input  logic             mpeg2_busy,
  output logic [7:0]       stream_data,
  output logic             stream_valid,
  output logic [CNT_W-1:0] byte_count,
  output logic             playing,
  output logic             underrun,
  output logic             protocol_err
);

  feed_state_e      state_r, state_nxt_s;
  logic             playing_r;
  logic             rd_en_r, rd_en_nxt_s;
  logic             valid_r, valid_nxt_s;
  logic [7:0]       data_r, data_nxt_s;
  logic [CNT_W-1:0] count_r;
  logic             underrun_r, underrun_nxt_s;
  logic             armed_r;
  logic             perr_r;
  logic             flush_d_r;
  logic             ser_load_s, ser_adv_s, ser_clear_s;
  logic [7:0]       ser_byte_s;
  logic             ser_last_s;

  ldp_word_serializer #(.BIG_ENDIAN(BIG_ENDIAN)) u_ser (
    .sys_clk   (sys_clk),
    .rst_n     (RESET_N),
    .clear     (ser_clear_s),
    .load      (ser_load_s),
    .word      (fifo_dout),
    .advance   (ser_adv_s),
    .cur_byte  (ser_byte_s),
    .last_byte (ser_last_s)
  );

  // Feed-enable register: pause wins over a simultaneous play.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      playing_r <= 1'b0;
    end else if (pause) begin
      playing_r <= 1'b0;
    end else if (play) begin
      playing_r <= 1'b1;
    end else begin
      playing_r <= playing_r;
    end
  end

  // FSM state register.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, next registered outputs and serializer controls; flush overrides all.
  always_comb begin
    state_nxt_s    = state_r;
    rd_en_nxt_s    = 1'b0;
    valid_nxt_s    = 1'b0;
    data_nxt_s     = 8'h00;
    ser_load_s     = 1'b0;
    ser_adv_s      = 1'b0;
    ser_clear_s    = 1'b0;
    underrun_nxt_s = 1'b0;
    if (flush) begin
      state_nxt_s = ST_IDLE;
      ser_clear_s = 1'b1;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (playing_r && !fifo_empty) begin
            rd_en_nxt_s = 1'b1;
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s    = ST_IDLE;
            underrun_nxt_s = playing_r && fifo_empty && armed_r;
          end
        end
        ST_WAIT: begin
          if (fifo_valid) begin
            ser_load_s  = 1'b1;
            state_nxt_s = ST_SEND;
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_SEND: begin
          if (playing_r && !mpeg2_busy) begin
            valid_nxt_s = 1'b1;
            data_nxt_s  = ser_byte_s;
            ser_adv_s   = 1'b1;
            if (!ser_last_s) begin
              state_nxt_s = ST_SEND;
            end else if (!fifo_empty) begin
              rd_en_nxt_s = 1'b1;
              state_nxt_s = ST_WAIT;
            end else begin
              state_nxt_s = ST_IDLE;
            end
          end else begin
            state_nxt_s = ST_SEND;
          end
        end
        default: state_nxt_s = ST_IDLE;
      endcase
    end
  end

  // Registered outputs, byte counter and status flags.
  always_ff @(posedge sys_clk or negedge RESET_N) begin
    if (!RESET_N) begin
      rd_en_r    <= 1'b0;
      valid_r    <= 1'b0;
      data_r     <= 8'h00;
      count_r    <= {CNT_W{1'b0}};
      underrun_r <= 1'b0;
      armed_r    <= 1'b0;
      perr_r     <= 1'b0;
      flush_d_r  <= 1'b0;
    end else begin
      rd_en_r    <= rd_en_nxt_s;
      valid_r    <= valid_nxt_s;
      data_r     <= data_nxt_s;
      underrun_r <= underrun_nxt_s;
      flush_d_r  <= flush;
      if (flush) begin
        count_r <= {CNT_W{1'b0}};
      end else if (valid_nxt_s) begin
        count_r <= count_r + CNT_W'(1);
      end else begin
        count_r <= count_r;
      end
      if (flush || underrun_nxt_s) begin
        armed_r <= 1'b0;
      end else if (valid_nxt_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
      // The read in flight when flush hit may still return one cycle later.
      if (flush) begin
        perr_r <= 1'b0;
      end else if (fifo_valid && (state_r != ST_WAIT) && !flush_d_r) begin
        perr_r <= 1'b1;
      end else begin
        perr_r <= perr_r;
      end
    end
  end

  assign fifo_rd_en   = rd_en_r;
  assign stream_valid = valid_r;
  assign stream_data  = data_r;
  assign byte_count   = count_r;
  assign playing      = playing_r;
  assign underrun     = underrun_r;
  assign protocol_err = perr_r;

endmodule

// File: tb/tb_mpeg_stream_feeder.sv
// Directed bench for mpeg_stream_feeder: cycle table for the main flow plus
// hand sequences for flush, protocol error and reset.
module tb_mpeg_stream_feeder;

  logic        sys_clk = 1'b0;
  logic        RESET_N, play, pause, flush, fifo_empty, fifo_valid, mpeg2_busy;
  logic [31:0] fifo_dout;
  logic        fifo_rd_en, stream_valid, playing, underrun, protocol_err;
  logic [7:0]  stream_data;
  logic [31:0] byte_count;
  logic        le_rd_en, le_valid, le_playing, le_underrun, le_perr;
  logic [7:0]  le_data;
  logic [31:0] le_count;

  int          total = 0;
  int          bad   = 0;
  logic [31:0] q[$];
  logic        inj_valid;
  logic [7:0]  got[$];
  logic [31:0] w;

  always #5 sys_clk = ~sys_clk;

  mpeg_stream_feeder #(.BIG_ENDIAN(1'b1), .CNT_W(32)) dut (
    .sys_clk(sys_clk), .RESET_N(RESET_N), .play(play), .pause(pause), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_rd_en(fifo_rd_en), .mpeg2_busy(mpeg2_busy), .stream_data(stream_data),
    .stream_valid(stream_valid), .byte_count(byte_count), .playing(playing),
    .underrun(underrun), .protocol_err(protocol_err)
  );

  mpeg_stream_feeder #(.BIG_ENDIAN(1'b0), .CNT_W(32)) dut_le (
    .sys_clk(sys_clk), .RESET_N(RESET_N), .play(play), .pause(pause), .flush(flush),
    .fifo_dout(fifo_dout), .fifo_empty(fifo_empty), .fifo_valid(fifo_valid),
    .fifo_rd_en(le_rd_en), .mpeg2_busy(mpeg2_busy), .stream_data(le_data),
    .stream_valid(le_valid), .byte_count(le_count), .playing(le_playing),
    .underrun(le_underrun), .protocol_err(le_perr)
  );

  typedef struct {
    logic        play, pause, busy, push;
    logic [31:0] word;
    logic        ev;
    logic [7:0]  ebe, ele;
    logic [31:0] ecnt;
    logic        eun, epl;
  } vec_t;

  vec_t vt[33];

  function automatic vec_t mk(input logic pl, input logic pa, input logic bz, input logic pu,
                              input logic [31:0] wd, input logic ev, input logic [7:0] ebe,
                              input logic [7:0] ele, input logic [31:0] ecnt, input logic eun,
                              input logic epl);
    vec_t v;
    v.play = pl; v.pause = pa; v.busy = bz; v.push = pu; v.word = wd;
    v.ev = ev; v.ebe = ebe; v.ele = ele; v.ecnt = ecnt; v.eun = eun; v.epl = epl;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One clock; the FIFO model answers a pop one cycle after fifo_rd_en.
  task automatic step();
    logic rd_seen;
    rd_seen = fifo_rd_en;
    @(posedge sys_clk);
    #1;
    if (rd_seen && q.size() > 0) begin
      fifo_dout  = q.pop_front();
      fifo_valid = 1'b1;
    end else begin
      fifo_dout  = 32'h0;
      fifo_valid = inj_valid;
    end
    fifo_empty = (q.size() == 0);
  endtask

  task automatic wait_rd();
    for (int k = 0; k < 10 && !fifo_rd_en; k++) step();
    check("wait_rd_en", {31'd0, fifo_rd_en}, 32'd1);
  endtask

  task automatic collect_word(input logic [31:0] exp_word, input string tag);
    logic [31:0] ew;
    ew = exp_word;
    got.delete();
    for (int k = 0; k < 20 && got.size() < 4; k++) begin
      step();
      if (stream_valid) got.push_back(stream_data);
    end
    check({tag, "_nbytes"}, got.size(), 32'd4);
    for (int j = 0; j < 4 && j < got.size(); j++)
      check($sformatf("%s_byte%0d", tag, j), {24'd0, got[j]}, {24'd0, ew[31-8*j -: 8]});
  endtask

  initial begin
    RESET_N = 1'b0; play = 1'b0; pause = 1'b0; flush = 1'b0; mpeg2_busy = 1'b0;
    fifo_empty = 1'b1; fifo_valid = 1'b0; fifo_dout = 32'h0; inj_valid = 1'b0;

    //          play  pause busy  push  word          ev    be     le     cnt    un    pl
    vt[0]  = mk(1'b1, 1'b0, 1'b0, 1'b1, 32'h000001B3, 1'b0, 8'h00, 8'h00, 32'd0, 1'b0, 1'b1);
    vt[1]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd0, 1'b0, 1'b1);
    vt[2]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd0, 1'b0, 1'b1);
    vt[3]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd0, 1'b0, 1'b1);
    vt[4]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h00, 8'hB3, 32'd1, 1'b0, 1'b1);
    vt[5]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h00, 8'h01, 32'd2, 1'b0, 1'b1);
    vt[6]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h01, 8'h00, 32'd3, 1'b0, 1'b1);
    vt[7]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'hB3, 8'h00, 32'd4, 1'b0, 1'b1);
    vt[8]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd4, 1'b1, 1'b1);
    vt[9]  = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd4, 1'b0, 1'b1);
    vt[10] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'hA1B2C3D4, 1'b0, 8'h00, 8'h00, 32'd4, 1'b0, 1'b1);
    vt[11] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd4, 1'b0, 1'b1);
    vt[12] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd4, 1'b0, 1'b1);
    vt[13] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'hA1, 8'hD4, 32'd5, 1'b0, 1'b1);
    vt[14] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'hB2, 8'hC3, 32'd6, 1'b0, 1'b1);
    vt[15] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd6, 1'b0, 1'b1);
    vt[16] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd6, 1'b0, 1'b1);
    vt[17] = mk(1'b0, 1'b0, 1'b1, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd6, 1'b0, 1'b1);
    vt[18] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'hC3, 8'hB2, 32'd7, 1'b0, 1'b1);
    vt[19] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'hD4, 8'hA1, 32'd8, 1'b0, 1'b1);
    vt[20] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd8, 1'b1, 1'b1);
    vt[21] = mk(1'b0, 1'b0, 1'b0, 1'b1, 32'h11223344, 1'b0, 8'h00, 8'h00, 32'd8, 1'b0, 1'b1);
    vt[22] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd8, 1'b0, 1'b1);
    vt[23] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd8, 1'b0, 1'b1);
    vt[24] = mk(1'b0, 1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 8'h11, 8'h44, 32'd9, 1'b0, 1'b0);
    vt[25] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd9, 1'b0, 1'b0);
    vt[26] = mk(1'b1, 1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd9, 1'b0, 1'b0);
    vt[27] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd9, 1'b0, 1'b0);
    vt[28] = mk(1'b1, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd9, 1'b0, 1'b1);
    vt[29] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h22, 8'h33, 32'd10, 1'b0, 1'b1);
    vt[30] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h33, 8'h22, 32'd11, 1'b0, 1'b1);
    vt[31] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 8'h44, 8'h11, 32'd12, 1'b0, 1'b1);
    vt[32] = mk(1'b0, 1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 8'h00, 8'h00, 32'd12, 1'b1, 1'b1);

    // Reset state
    step(); step();
    #2 RESET_N = 1'b1;
    step();
    check("rst_valid", {31'd0, stream_valid}, 32'd0);
    check("rst_data", {24'd0, stream_data}, 32'd0);
    check("rst_count", byte_count, 32'd0);
    check("rst_playing", {31'd0, playing}, 32'd0);
    check("rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("rst_underrun", {31'd0, underrun}, 32'd0);
    check("rst_perr", {31'd0, protocol_err}, 32'd0);

    // Cycle table: basic order, back-pressure, pause/resume, both endians
    for (int i = 0; i < 33; i++) begin
      play = vt[i].play; pause = vt[i].pause; mpeg2_busy = vt[i].busy;
      if (vt[i].push) begin
        q.push_back(vt[i].word);
        fifo_empty = 1'b0;
      end
      step();
      play = 1'b0; pause = 1'b0; mpeg2_busy = 1'b0;
      check($sformatf("v%0d_valid", i), {31'd0, stream_valid}, {31'd0, vt[i].ev});
      check($sformatf("v%0d_data", i), {24'd0, stream_data}, {24'd0, vt[i].ebe});
      check($sformatf("v%0d_le_valid", i), {31'd0, le_valid}, {31'd0, vt[i].ev});
      check($sformatf("v%0d_le_data", i), {24'd0, le_data}, {24'd0, vt[i].ele});
      check($sformatf("v%0d_count", i), byte_count, vt[i].ecnt);
      check($sformatf("v%0d_underrun", i), {31'd0, underrun}, {31'd0, vt[i].eun});
      check($sformatf("v%0d_playing", i), {31'd0, playing}, {31'd0, vt[i].epl});
      check($sformatf("v%0d_perr", i), {31'd0, protocol_err}, 32'd0);
    end

    // Flush in the fifo_rd_en cycle: returning word lands in IDLE and is dropped
    q.push_back(32'h0BAD0BAD); q.push_back(32'hDEADBEEF); q.push_back(32'hCAFEF00D);
    fifo_empty = 1'b0;
    wait_rd();
    flush = 1'b1; step(); flush = 1'b0;
    check("fl1_count", byte_count, 32'd0);
    check("fl1_valid", {31'd0, stream_valid}, 32'd0);
    step();
    check("fl1_discard_perr", {31'd0, protocol_err}, 32'd0);
    // Flush in the cycle after fifo_rd_en, coinciding with fifo_valid
    wait_rd();
    step();
    flush = 1'b1; step(); flush = 1'b0;
    check("fl2_count", byte_count, 32'd0);
    check("fl2_perr", {31'd0, protocol_err}, 32'd0);
    collect_word(32'hCAFEF00D, "fl2");
    check("fl2_count_after", byte_count, 32'd4);
    check("fl2_perr_after", {31'd0, protocol_err}, 32'd0);

    // Stray fifo_valid in IDLE sets the sticky error until flush
    step(); step(); step();
    inj_valid = 1'b1; step(); inj_valid = 1'b0;
    step();
    check("perr_set", {31'd0, protocol_err}, 32'd1);
    check("perr_set_le", {31'd0, le_perr}, 32'd1);
    step(); step(); step();
    check("perr_sticky", {31'd0, protocol_err}, 32'd1);
    flush = 1'b1; step(); flush = 1'b0;
    check("perr_cleared", {31'd0, protocol_err}, 32'd0);

    // Asynchronous reset mid-SEND
    q.push_back(32'h01020304); fifo_empty = 1'b0;
    for (int k = 0; k < 10 && !stream_valid; k++) step();
    check("pre_rst_valid", {31'd0, stream_valid}, 32'd1);
    #2 RESET_N = 1'b0;
    #1;
    check("arst_valid", {31'd0, stream_valid}, 32'd0);
    check("arst_data", {24'd0, stream_data}, 32'd0);
    check("arst_count", byte_count, 32'd0);
    check("arst_playing", {31'd0, playing}, 32'd0);
    check("arst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    #3 RESET_N = 1'b1;
    step(); step();
    check("post_rst_valid", {31'd0, stream_valid}, 32'd0);
    check("post_rst_rd_en", {31'd0, fifo_rd_en}, 32'd0);
    check("post_rst_count", byte_count, 32'd0);
    q.push_back(32'h0A0B0C0D); fifo_empty = 1'b0;
    play = 1'b1; step(); play = 1'b0;
    collect_word(32'h0A0B0C0D, "post_rst");
    check("post_rst_count_after", byte_count, 32'd4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
